// File: rtl/rv_trace_fifo.sv
// Commit-trace capture buffer: packs up to two writeback/memory events per cycle into a circular buffer.
// Optional per-entry 16-bit capture timestamps when TRACE_TIMESTAMP_EN is defined.
module rv_trace_fifo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 16,
   parameter int DROP_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     halt,
   input  logic                     reg_write_sig,
   input  logic [4:0]               reg_num,
   input  logic [DATA_W-1:0]        reg_data,
   input  logic                     wr,
   input  logic                     rd,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W-1:0]        rd_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_kind,
   output logic [ADDR_W-1:0]        out_tag,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [DROP_W-1:0]        dropped,
   output logic                     frozen
`ifdef TRACE_TIMESTAMP_EN
   ,
   output logic [15:0]              out_ts
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] KIND_REG  = 2'b01;
   localparam logic [1:0] KIND_MEMW = 2'b10;
   localparam logic [1:0] KIND_MEMR = 2'b11;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_FROZEN = 1'b1
   } state_t;

   typedef struct packed {
      logic [1:0]        kind;
      logic [ADDR_W-1:0] tag;
      logic [DATA_W-1:0] data;
   } ent_t;

   function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                 input logic [1:0]        b);
      logic [DROP_W:0] sum;
      sum = {1'b0, a} + (DROP_W+1)'(b);
      if (sum[DROP_W]) return '1;
      return sum[DROP_W-1:0];
   endfunction

   state_t            state_q;
   logic              frozen_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic              ovf_q, ovf_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   ent_t              mem_q [DEPTH];

   logic              capture;
   logic              mem_ev, reg_ev;
   ent_t              mem_ent, reg_ent;
   logic              s0_vld, s1_vld;
   ent_t              s0_ent;
   logic [CNT_W-1:0]  free_slots;
   logic              push0, push1, pop;
   logic [1:0]        ndrop;
   logic [PTR_W-1:0]  wptr_p1;
   ent_t              head;

   assign capture = (state_q == ST_RUN);
   assign wptr_p1 = wptr_q + PTR_W'(1);
   assign head    = mem_q[rptr_q];

   // Qualify this cycle's events; slot 0 is the MEM event when present, otherwise the REG event.
   always_comb begin
      mem_ev       = capture & (wr | rd);
      reg_ev       = capture & reg_write_sig & (reg_num != 5'd0);
      mem_ent.kind = wr ? KIND_MEMW : KIND_MEMR;
      mem_ent.tag  = addr;
      mem_ent.data = wr ? wr_data : rd_data;
      reg_ent.kind = KIND_REG;
      reg_ent.tag  = ADDR_W'(reg_num);
      reg_ent.data = reg_data;
      s0_vld       = mem_ev | reg_ev;
      s1_vld       = mem_ev & reg_ev;
      s0_ent       = mem_ev ? mem_ent : reg_ent;
      free_slots   = CNT_W'(DEPTH) - count_q;
      push0        = s0_vld & (free_slots != '0) & ~clear;
      push1        = s1_vld & (free_slots >= CNT_W'(2)) & ~clear;
      ndrop        = {1'b0, s0_vld & (free_slots == '0)} +
                     {1'b0, s1_vld & (free_slots < CNT_W'(2))};
      pop          = out_valid & out_ready;
   end

   always_comb begin
      count_d = count_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      ovf_d   = ovf_q;
      drop_d  = drop_q;
      if (clear) begin
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
         ovf_d   = 1'b0;
         drop_d  = '0;
      end else begin
         count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
         wptr_d  = wptr_q + PTR_W'(push0) + PTR_W'(push1);
         rptr_d  = rptr_q + PTR_W'(pop);
         if (ndrop != 2'd0) begin
            ovf_d  = 1'b1;
            drop_d = sat_add(drop_q, ndrop);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_RUN;
         frozen_q <= 1'b0;
         count_q  <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
         if (clear) begin
            state_q  <= ST_RUN;
            frozen_q <= 1'b0;
         end else if (state_q == ST_RUN && halt) begin
            state_q  <= ST_FROZEN;
            frozen_q <= 1'b1;
         end
      end
   end

   // Payload storage carries no reset; an empty buffer masks it at the outputs.
   always_ff @(posedge clk) begin
      if (push0) mem_q[wptr_q]  <= s0_ent;
      if (push1) mem_q[wptr_p1] <= reg_ent;
   end

   assign out_valid = (count_q != '0);
   assign out_kind  = out_valid ? head.kind : '0;
   assign out_tag   = out_valid ? head.tag  : '0;
   assign out_data  = out_valid ? head.data : '0;
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign dropped   = drop_q;
   assign frozen    = frozen_q;

`ifdef TRACE_TIMESTAMP_EN
   logic [15:0] ts_q, ts_d;
   logic [15:0] ts_mem_q [DEPTH];

   assign ts_d = clear ? 16'd0 : ts_q + 16'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ts_q <= '0;
      else        ts_q <= ts_d;
   end

   // Both events of one cycle share the capture-cycle stamp.
   always_ff @(posedge clk) begin
      if (push0) ts_mem_q[wptr_q]  <= ts_q;
      if (push1) ts_mem_q[wptr_p1] <= ts_q;
   end

   assign out_ts = out_valid ? ts_mem_q[rptr_q] : '0;
`endif

endmodule

// File: tb/tb_rv_trace_fifo.sv
// Bench for rv_trace_fifo: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rv_trace_fifo;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, clear, halt, reg_write_sig, wr, rd, out_ready;
   logic [4:0]        reg_num;
   logic [DATA_W-1:0] reg_data, wr_data, rd_data;
   logic [ADDR_W-1:0] addr;

   logic              out_valid, overflow, frozen;
   logic [1:0]        out_kind;
   logic [ADDR_W-1:0] out_tag;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  count;
   logic [15:0]       dropped;

   logic              s_out_valid, s_overflow, s_frozen;
   logic [1:0]        s_out_kind;
   logic [ADDR_W-1:0] s_out_tag;
   logic [DATA_W-1:0] s_out_data;
   logic [CNT_W-1:0]  s_count;
   logic [1:0]        s_dropped;
`ifdef TRACE_TIMESTAMP_EN
   logic [15:0]       out_ts, s_out_ts;
`endif

   rv_trace_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DROP_W(16)) dut (
      .clk(clk), .reset(reset), .clear(clear), .halt(halt),
      .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
      .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
      .out_tag(out_tag), .out_data(out_data), .count(count),
      .overflow(overflow), .dropped(dropped), .frozen(frozen)
`ifdef TRACE_TIMESTAMP_EN
      , .out_ts(out_ts)
`endif
   );

   rv_trace_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DROP_W(2)) dut_s (
      .clk(clk), .reset(reset), .clear(clear), .halt(halt),
      .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
      .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_kind(s_out_kind),
      .out_tag(s_out_tag), .out_data(s_out_data), .count(s_count),
      .overflow(s_overflow), .dropped(s_dropped), .frozen(s_frozen)
`ifdef TRACE_TIMESTAMP_EN
      , .out_ts(s_out_ts)
`endif
   );

   typedef struct packed {
      logic [1:0]        kind;
      logic [ADDR_W-1:0] tag;
      logic [DATA_W-1:0] data;
      logic [15:0]       ts;
   } ent_t;

   int n_vec = 0;
   int n_err = 0;

   ent_t        mq[$];
   bit          m_frozen, m_ovf;
   int          m_drop, m_drop_s;
   logic [15:0] m_ts;

   task automatic m_reset();
      mq.delete();
      m_frozen = 0; m_ovf = 0; m_drop = 0; m_drop_s = 0; m_ts = 16'd0;
   endtask

   // One clock of the reference behaviour, evaluated from the inputs present before the edge.
   task automatic m_step();
      ent_t ev[$];
      ent_t e;
      int   free_n;
      bit   do_pop;
      if (clear) begin
         m_reset();
         return;
      end
      do_pop = (mq.size() != 0) && out_ready;
      free_n = DEPTH - mq.size();
      if (!m_frozen) begin
         if (wr || rd) begin
            e.kind = wr ? 2'b10 : 2'b11;
            e.tag  = addr;
            e.data = wr ? wr_data : rd_data;
            e.ts   = m_ts;
            ev.push_back(e);
         end
         if (reg_write_sig && reg_num != 5'd0) begin
            e.kind = 2'b01;
            e.tag  = {4'b0, reg_num};
            e.data = reg_data;
            e.ts   = m_ts;
            ev.push_back(e);
         end
      end
      if (do_pop) void'(mq.pop_front());
      foreach (ev[i]) begin
         if (free_n > 0) begin
            mq.push_back(ev[i]);
            free_n--;
         end else begin
            m_ovf = 1;
            if (m_drop < 65535) m_drop++;
            if (m_drop_s < 3) m_drop_s++;
         end
      end
      if (halt && !m_frozen) m_frozen = 1;
      m_ts = m_ts + 16'd1;
   endtask

   task automatic cycle();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clear = 0; halt = 0; reg_write_sig = 0; reg_num = 0; reg_data = 0;
      wr = 0; rd = 0; addr = 0; wr_data = 0; rd_data = 0;
   endtask

   task automatic test_reset();
      idle();
      out_ready = 0;
      reset = 0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
      n_vec++; if ({out_kind, out_tag, out_data} !== '0) begin n_err++; $display("FAIL reset_head: got %0h/%0h/%0h want 0", out_kind, out_tag, out_data); end
      n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
      n_vec++; if ({overflow, dropped, frozen} !== '0) begin n_err++; $display("FAIL reset_flags: ovf %0b drop %0d frz %0b want 0", overflow, dropped, frozen); end
      #1 reset = 1;
      m_reset();
   endtask

   task automatic test_single_reg();
      reg_write_sig = 1; reg_num = 5'd5; reg_data = 32'hDEADBEEF;
      cycle();
      idle();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %0b want 1", out_valid); end
      n_vec++; if (out_kind !== 2'b01) begin n_err++; $display("FAIL single_kind: got %0b want 01", out_kind); end
      n_vec++; if (out_tag !== 9'd5) begin n_err++; $display("FAIL single_tag: got %0h want 5", out_tag); end
      n_vec++; if (out_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %0h want deadbeef", out_data); end
      n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", count); end
      out_ready = 1;
      cycle();
      out_ready = 0;
      n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL single_drain: got %0d want 0", count); end
   endtask

   task automatic test_dual();
      wr = 1; addr = 9'h1A0; wr_data = 32'h11;
      reg_write_sig = 1; reg_num = 5'd3; reg_data = 32'h22;
      cycle();
      idle();
      n_vec++; if (count !== 5'd2) begin n_err++; $display("FAIL dual_count: got %0d want 2", count); end
      n_vec++; if ({out_kind, out_tag, out_data} !== {2'b10, 9'h1A0, 32'h11}) begin n_err++; $display("FAIL dual_first: got %0b/%0h/%0h want 10/1a0/11", out_kind, out_tag, out_data); end
      out_ready = 1;
      cycle();
      out_ready = 0;
      n_vec++; if ({out_kind, out_tag, out_data} !== {2'b01, 9'd3, 32'h22}) begin n_err++; $display("FAIL dual_second: got %0b/%0h/%0h want 01/3/22", out_kind, out_tag, out_data); end
      out_ready = 1;
      cycle();
      out_ready = 0;
      n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL dual_drain: got %0d want 0", count); end
   endtask

   task automatic test_x0_rdwr();
      reg_write_sig = 1; reg_num = 5'd0; reg_data = 32'h1234;
      cycle();
      idle();
      n_vec++; if ({out_valid, count} !== 6'd0) begin n_err++; $display("FAIL x0_ignored: valid %0b count %0d want 0/0", out_valid, count); end
      wr = 1; rd = 1; addr = 9'h055; wr_data = 32'hAAAA; rd_data = 32'hBBBB;
      cycle();
      idle();
      n_vec++; if (count !== 5'd1) begin n_err++; $display("FAIL rdwr_count: got %0d want 1", count); end
      n_vec++; if ({out_kind, out_data} !== {2'b10, 32'hAAAA}) begin n_err++; $display("FAIL rdwr_entry: got %0b/%0h want 10/aaaa", out_kind, out_data); end
      out_ready = 1;
      cycle();
      out_ready = 0;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 15; i++) begin
         reg_write_sig = 1; reg_num = 5'(i + 1); reg_data = 32'(i);
         cycle();
      end
      n_vec++; if (count !== 5'd15) begin n_err++; $display("FAIL ovf_fill: got %0d want 15", count); end
      wr = 1; addr = 9'h0F0; wr_data = 32'hCAFE;
      reg_write_sig = 1; reg_num = 5'd20; reg_data = 32'h99;
      cycle();
      n_vec++; if (count !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d want 16", count); end
      n_vec++; if ({overflow, dropped} !== {1'b1, 16'd1}) begin n_err++; $display("FAIL ovf_first_drop: ovf %0b drop %0d want 1/1", overflow, dropped); end
      n_vec++; if (s_dropped !== 2'd1) begin n_err++; $display("FAIL ovf_small_drop1: got %0d want 1", s_dropped); end
      repeat (3) cycle();
      idle();
      n_vec++; if (dropped !== 16'd7) begin n_err++; $display("FAIL ovf_drop_count: got %0d want 7", dropped); end
      n_vec++; if (s_dropped !== 2'd3) begin n_err++; $display("FAIL ovf_saturate: got %0d want 3", s_dropped); end
      out_ready = 1;
      for (int i = 0; i < 16; i++) begin
         n_vec++; if ({out_kind, out_tag} !== {mq[0].kind, mq[0].tag}) begin n_err++; $display("FAIL ovf_drain_head%0d: got %0b/%0h want %0b/%0h", i, out_kind, out_tag, mq[0].kind, mq[0].tag); end
         if (i == 15) begin
            n_vec++; if ({out_kind, out_tag, out_data} !== {2'b10, 9'h0F0, 32'hCAFE}) begin n_err++; $display("FAIL ovf_last_mem: got %0b/%0h/%0h want 10/f0/cafe", out_kind, out_tag, out_data); end
         end
         cycle();
      end
      out_ready = 0;
      n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL ovf_drained: got %0d want 0", count); end
      clear = 1;
      cycle();
      clear = 0;
      n_vec++; if ({overflow, dropped, s_dropped} !== '0) begin n_err++; $display("FAIL ovf_clear: ovf %0b drop %0d sdrop %0d want 0", overflow, dropped, s_dropped); end
   endtask

   task automatic test_halt_freeze();
      halt = 1; reg_write_sig = 1; reg_num = 5'd7; reg_data = 32'h77;
      cycle();
      idle();
      n_vec++; if ({frozen, count, out_tag} !== {1'b1, 5'd1, 9'd7}) begin n_err++; $display("FAIL halt_capture: frz %0b count %0d tag %0h want 1/1/7", frozen, count, out_tag); end
      for (int i = 0; i < 3; i++) begin
         reg_write_sig = 1; reg_num = 5'd9; wr = 1; addr = 9'(i);
         cycle();
      end
      idle();
      n_vec++; if ({count, overflow} !== {5'd1, 1'b0}) begin n_err++; $display("FAIL halt_ignore: count %0d ovf %0b want 1/0", count, overflow); end
      out_ready = 1;
      cycle();
      out_ready = 0;
      n_vec++; if ({count, frozen} !== {5'd0, 1'b1}) begin n_err++; $display("FAIL halt_drain: count %0d frz %0b want 0/1", count, frozen); end
      clear = 1;
      cycle();
      clear = 0;
      n_vec++; if (frozen !== 1'b0) begin n_err++; $display("FAIL halt_clear: got %0b want 0", frozen); end
      reg_write_sig = 1; reg_num = 5'd4; reg_data = 32'h44;
      cycle();
      idle();
      n_vec++; if ({count, out_tag, out_data} !== {5'd1, 9'd4, 32'h44}) begin n_err++; $display("FAIL halt_resume: count %0d tag %0h data %0h want 1/4/44", count, out_tag, out_data); end
      out_ready = 1;
      cycle();
      out_ready = 0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 9; i++) begin
         reg_write_sig = 1; reg_num = 5'(i + 10); reg_data = 32'(i * 3);
         cycle();
      end
      idle();
      n_vec++; if (count !== 5'd9) begin n_err++; $display("FAIL areset_fill: got %0d want 9", count); end
      out_ready = 1;
      #2 reset = 0;
      #1;
      n_vec++; if ({count, out_valid} !== 6'd0) begin n_err++; $display("FAIL areset_immediate: count %0d valid %0b want 0/0", count, out_valid); end
      out_ready = 0;
      m_reset();
      #2 reset = 1;
      cycle();
      n_vec++; if (count !== 5'd0) begin n_err++; $display("FAIL areset_after: got %0d want 0", count); end
   endtask

`ifdef TRACE_TIMESTAMP_EN
   task automatic test_timestamp();
      logic [15:0] t0;
      reg_write_sig = 1; reg_num = 5'd1; reg_data = 32'h1;
      cycle();
      idle();
      cycle();
      cycle();
      reg_write_sig = 1; reg_num = 5'd2; reg_data = 32'h2;
      cycle();
      idle();
      t0 = out_ts;
      n_vec++; if (out_ts !== mq[0].ts) begin n_err++; $display("FAIL ts_first: got %0d want %0d", out_ts, mq[0].ts); end
      out_ready = 1;
      cycle();
      n_vec++; if (out_ts - t0 !== 16'd3) begin n_err++; $display("FAIL ts_delta: got %0d want 3", out_ts - t0); end
      cycle();
      out_ready = 0;
   endtask
`endif

   task automatic test_random();
      ent_t hd;
      bit   ev;
      for (int i = 0; i < 600; i++) begin
         clear         = ($urandom_range(0, 59) == 0);
         halt          = ($urandom_range(0, 29) == 0);
         reg_write_sig = $urandom_range(0, 1) == 1;
         reg_num       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         reg_data      = $urandom;
         wr            = ($urandom_range(0, 2) == 0);
         rd            = ($urandom_range(0, 2) == 0);
         addr          = ADDR_W'($urandom);
         wr_data       = $urandom;
         rd_data       = $urandom;
         out_ready     = ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         cycle();
         ev = (mq.size() != 0);
         hd = ev ? mq[0] : '0;
         n_vec++; if (out_valid !== ev) begin n_err++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", i, out_valid, ev); end
         n_vec++; if ({out_kind, out_tag, out_data} !== {hd.kind, hd.tag, hd.data}) begin n_err++; $display("FAIL rnd_head[%0d]: got %0b/%0h/%0h want %0b/%0h/%0h", i, out_kind, out_tag, out_data, hd.kind, hd.tag, hd.data); end
         n_vec++; if (count !== CNT_W'(mq.size())) begin n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, count, mq.size()); end
         n_vec++; if ({overflow, frozen} !== {m_ovf, m_frozen}) begin n_err++; $display("FAIL rnd_flags[%0d]: ovf %0b frz %0b want %0b/%0b", i, overflow, frozen, m_ovf, m_frozen); end
         n_vec++; if (dropped !== 16'(m_drop)) begin n_err++; $display("FAIL rnd_dropped[%0d]: got %0d want %0d", i, dropped, m_drop); end
         n_vec++; if ({s_out_valid, s_out_kind, s_out_tag, s_out_data, s_count, s_overflow, s_frozen, s_dropped} !==
                      {ev, hd.kind, hd.tag, hd.data, CNT_W'(mq.size()), m_ovf, m_frozen, 2'(m_drop_s)}) begin
            n_err++; $display("FAIL rnd_small[%0d]: count %0d sdrop %0d want %0d/%0d", i, s_count, s_dropped, mq.size(), m_drop_s);
         end
`ifdef TRACE_TIMESTAMP_EN
         n_vec++; if ({out_ts, s_out_ts} !== {hd.ts, hd.ts}) begin n_err++; $display("FAIL rnd_ts[%0d]: got %0d want %0d", i, out_ts, hd.ts); end
`endif
      end
      idle();
      out_ready = 0;
   endtask

   initial begin
      test_reset();
      test_single_reg();
      test_dual();
      test_x0_rdwr();
      test_overflow();
      test_halt_freeze();
      test_async_reset();
`ifdef TRACE_TIMESTAMP_EN
      test_timestamp();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rv_trace_fifo.md
# rv_trace_fifo

Parametrised commit-trace capture unit for the RISC-V core. It samples the core's register-writeback and data-memory observation outputs every cycle and packs up to two events per cycle into a circular buffer. A valid/ready stream drains the buffer. Capture freezes on halt, so the last DEPTH events before a stop are preserved for the test harness or debug host.

## Interface
- DATA_W, 32, width of register and memory data
- ADDR_W, 9, width of the data-memory address
- DEPTH, 16, buffer entries; power of two, at least 4
- DROP_W, 16, width of the dropped-event counter

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- clear  in  1  synchronous: empties the buffer, clears overflow/dropped, returns to RUN
- halt  in  1  core halt indication
- reg_write_sig  in  1  register-file write this cycle
- reg_num  in  5  destination register
- reg_data  in  DATA_W  writeback data
- wr  in  1  data-memory write
- rd  in  1  data-memory read
- addr  in  ADDR_W  data-memory address
- wr_data  in  DATA_W  store data
- rd_data  in  DATA_W  load data
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_kind  out  2  head type: 01 REG, 10 MEMW, 11 MEMR
- out_tag  out  ADDR_W  head tag: reg_num zero-extended, or addr
- out_data  out  DATA_W  head data
- count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky; set when any event is dropped
- dropped  out  DROP_W  saturating count of dropped events
- frozen  out  1  state is FROZEN

## Operation
- States: RUN and FROZEN.
  - RUN goes to FROZEN on a cycle where halt=1; events in that same cycle are still captured.
  - FROZEN goes to RUN only on clear.
  - Reset enters RUN.
- Event qualification, RUN only:
  - MEM event: wr=1 gives MEMW with data wr_data; otherwise rd=1 gives MEMR with data rd_data. wr and rd together count as MEMW only.
  - REG event: reg_write_sig=1 and reg_num≠0. Writes to x0 are never traced.
- Push order within a cycle: MEM event first, then REG event.
- Space check uses count at the start of the cycle; a same-cycle pop does not free space.
  - If free ≥ needed, all events are pushed.
  - If free = 1 with two events, the MEM event is pushed and the REG event is dropped.
  - If free = 0, all events are dropped.
- Each dropped event:
  - sets overflow;
  - increments dropped, which saturates at 2^DROP_W−1.
- Pop: out_valid && out_ready advances the head. Pops continue in FROZEN.
- Pointers wrap modulo DEPTH. count = pushes − pops.
- clear has priority over push and pop in the same cycle. It sets count=0, both pointers=0, overflow=0, dropped=0, state RUN.
- Consumer must hold out_ready meaningfully only while out_valid=1. out_kind, out_tag and out_data are stable while out_valid=1 and no pop occurs.

## Timing
- Reset values: out_valid=0, out_kind=0, out_tag=0, out_data=0, count=0, overflow=0, dropped=0, frozen=0.
- Capture latency is 1 cycle: an event at edge N is visible at the head after edge N when the buffer was empty.
- No combinational path from inputs to out_* except out_valid, which is count≠0 from registers. out_ready affects state only.
- Throughput: 2 pushes and 1 pop per cycle.
- reset asserted mid-operation discards all contents immediately, without waiting for a clock.

## Configuration
- TRACE_TIMESTAMP_EN
  - Defined:
    - adds a 16-bit free-running cycle counter, cleared by reset and clear, that wraps at 65535→0;
    - each entry stores the counter value of its capture cycle;
    - an extra output out_ts [15:0] presents the head timestamp; its reset value is 0.
    - Both events of one cycle carry the same timestamp.
  - Undefined: no counter, no timestamp storage, no out_ts port.

## Test plan
- Single REG event: reg_write_sig=1, reg_num=5, reg_data=0xDEADBEEF, out_ready=0 → next cycle out_valid=1, out_kind=01, out_tag=5, out_data=0xDEADBEEF, count=1.
- Dual event: wr=1, addr=0x1A0, wr_data=0x11 plus reg write x3=0x22 in one cycle → two entries, MEMW 0x1A0/0x11 first, then REG 3/0x22; count=2.
- x0 and rd+wr: reg_num=0 with reg_write_sig=1 → nothing pushed; rd=1 and wr=1 together → one MEMW entry only.
- Overflow: DEPTH=16, fill to 15, then one dual-event cycle → MEM pushed, REG dropped, count=16, overflow=1, dropped=1. Further events with out_ready=0 increment dropped; it saturates when DROP_W is forced to 2 (value 3).
- Halt freeze: halt=1 together with reg write x7 → x7 captured, frozen=1. Later events are ignored. Draining with out_ready=1 empties to count=0. clear → frozen=0 and capture resumes.
- Async reset mid-drain: assert reset low between edges with count=9 → count=0, out_valid=0 immediately. With TRACE_TIMESTAMP_EN defined, entries captured 3 cycles apart differ in out_ts by 3.
